mux_tree_pipe: RTL
==================

# mux_tree_pipe

Parametrised, pipelined N-to-1 multiplexer tree with a valid/ready handshake on both sides. It generalises the fixed 2-to-1 cascades used in the mux benchmarks to arbitrary power-of-two input count and data width. The block registers each tree level, or only the output, and carries the select alongside the data so downstream logic can tell which source was chosen. It sits between N parallel producers and a single consumer that may apply backpressure.

## Interface
Parameters:
- `WIDTH`, 8: bits per data input and output; must be ≥1.
- `N_IN`, 4: number of data inputs; power of two, ≥2.
- `PIPE`, 1: 1 = register after every tree level; 0 = one output register only.
- Derived `LEVELS` = log2(`N_IN`), `SEL_W` = `LEVELS`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  input beat present.
- `in_ready`  out  1  block accepts a beat this cycle.
- `in_data`  in  `N_IN*WIDTH`  packed inputs; input i is bits [i*WIDTH +: WIDTH].
- `in_sel`  in  `SEL_W`  index of the input to forward.
- `out_valid`  out  1  output beat present.
- `out_ready`  in  1  consumer accepts the output.
- `out_data`  out  `WIDTH`  selected data.
- `out_sel`  out  `SEL_W`  select value that produced `out_data`.

## Operation
- Tree level k (k = 0 .. `LEVELS`-1) halves the candidate count and is steered by `in_sel[k]`, LSB first. Pair (2j, 2j+1) feeds node j: `sel` bit 0 selects even, bit 1 selects odd.
- Select bits not yet consumed travel with the data through each pipeline register.
- Each stage register holds {valid, data, remaining sel, original sel}.
- Global advance enable: `adv = !out_valid || out_ready`.
- `in_ready = adv`; this is combinational and has no dependence on `in_valid`.
- On `adv`, every stage loads from its predecessor, including its valid bit. Stage 0 loads from the inputs and takes valid = `in_valid`.
- On `!adv`, every stage holds its contents. Bubbles do not collapse; this is intentional, for a simple stall path.
- Data and sel registers load only when the incoming valid is 1, so invalid beats leave stale data. The valid bit always loads on `adv`.
- An input transfer is `in_valid && in_ready`. An output transfer is `out_valid && out_ready`.
- A simultaneous output transfer and input transfer in the same cycle is legal and gives full throughput of 1 beat/cycle.
- `in_sel` always falls within 0..`N_IN`-1 because `N_IN` is a power of two, so there is no out-of-range case.

## Timing
- Reset, asynchronous on `rst_n` low: all stage valid bits, data and sel registers clear to 0. Consequently `out_valid`=0, `out_data`=0 and `out_sel`=0. `in_ready` is 1 during and after reset.
- Latency, from input transfer at edge t to `out_valid` high:
  - `PIPE`=1: `LEVELS` cycles; the result is visible after edge t+`LEVELS`-1.
  - `PIPE`=0: 1 cycle; the whole tree is combinational into the output register.
- Reset asserted mid-operation discards all in-flight beats immediately. Nothing is replayed.
- While `out_valid` && !`out_ready`, `out_data` and `out_sel` hold stable. No upstream stage changes.
- Ordering: beats leave in acceptance order. No reordering, no duplication, no loss.

## Structure
- Shared package `mux_pkg`: `sel_bits` function (log2 of a power of two) and a parameter-check macro. The check fails elaboration when `N_IN` is not a power of two or `WIDTH` < 1.
- One sub-module, `mux_tree_level`. It is parametrised by node count and `WIDTH`, is purely combinational, and produces one level's 2:1 reduction.
- The top generates `LEVELS` instances of `mux_tree_level`. When `PIPE`=1 it inserts a stage register after each; when `PIPE`=0 it inserts a stage register after the last only.
- Handshake logic stays in the top: `adv` plus the valid chain.

## Test plan
- Reset: hold `rst_n`=0 with random inputs → `out_valid`=0, `out_data`=0, `out_sel`=0, `in_ready`=1.
- Basic select, `N_IN`=4, `WIDTH`=8, `PIPE`=1: inputs {0x11,0x22,0x33,0x44}, `in_sel`=2, one beat → after 2 cycles `out_data`=0x33, `out_sel`=2, `out_valid` high for one cycle with `out_ready`=1.
- Streaming: `out_ready`=1, `in_sel` walking 0,1,2,3 on consecutive cycles → outputs 0x11,0x22,0x33,0x44 on consecutive cycles after `LEVELS` latency; `in_ready` stays 1.
- Backpressure: drive `out_ready`=0 for 5 cycles with the pipe full → `in_ready`=0, `out_data` and `out_sel` stable. On release, the held beats drain in order with none dropped.
- Reset mid-stream: assert `rst_n`=0 with 2 beats in flight → `out_valid`=0 immediately. After release, the first new beat emerges alone at the correct latency.
- `PIPE`=0, `N_IN`=8, `WIDTH`=16: `in_sel`=7 with input 7 = 0xBEEF → `out_data`=0xBEEF one cycle after acceptance.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared helpers for the mux tree: select-width function and parameter check.
`ifndef MUX_PKG_SV
`define MUX_PKG_SV

// Elaboration-time guard: N_IN must be a power of two >= 2 and WIDTH >= 1.
`define MUX_PARAM_CHECK(n_in, width) \
  if (((n_in) < 2) || ((((n_in) & ((n_in) - 1))) != 0) || ((width) < 1)) begin : g_param_err \
    $error("mux_tree_pipe: N_IN must be a power of two >= 2 and WIDTH must be >= 1"); \
  end

package mux_pkg;

  // log2 of a power of two: number of select bits needed to address n inputs.
  function automatic int unsigned sel_bits(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

`endif

// File: rtl/mux_tree_pipe_if.sv
// Producer/consumer handshake bundle for the mux tree.
interface mux_tree_pipe_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N_IN  = 4
);
  localparam int unsigned SEL_W = mux_pkg::sel_bits(N_IN);

  logic                    in_valid;
  logic                    in_ready;
  logic [N_IN*WIDTH-1:0]   in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;

  // Environment side: drives the producers' beat and the consumer's ready.
  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  // Block side.
  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/mux_tree_level.sv
// One combinational tree level: NODES 2:1 muxes, pair (2j, 2j+1) feeds node j.
module mux_tree_level #(
  parameter int unsigned NODES = 1,
  parameter int unsigned WIDTH = 8
) (
  input  logic [2*NODES*WIDTH-1:0] pairs,
  input  logic                     sel,
  output logic [NODES*WIDTH-1:0]   reduced_c
);

  // sel = 0 picks the even member of each pair, sel = 1 the odd one.
  always_comb begin
    reduced_c = '0;
    for (int unsigned j = 0; j < NODES; j++) begin
      reduced_c[j*WIDTH +: WIDTH] = sel ? pairs[(2*j+1)*WIDTH +: WIDTH]
                                        : pairs[(2*j)*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined N:1 mux tree with valid/ready on both sides and a global stall.
module mux_tree_pipe
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N_IN  = 4,
  parameter int unsigned PIPE  = 1
) (
  input logic             clk,
  input logic             rst_n,
  mux_tree_pipe_if.slave  bus
);

  localparam int unsigned LEVELS = sel_bits(N_IN);
  localparam int unsigned SEL_W  = LEVELS;

  `MUX_PARAM_CHECK(N_IN, WIDTH)

  logic adv;

  // The whole pipe moves together: it advances unless the output is stuck.
  assign adv         = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  // Each level carries the original select; bit k of it is the remaining
  // select bit consumed at level k, so the unconsumed bits travel with the data.
  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int unsigned NODES = N_IN >> (k + 1);

    logic                     src_valid;
    logic [2*NODES*WIDTH-1:0] src_data;
    logic [SEL_W-1:0]         src_sel;
    logic [NODES*WIDTH-1:0]   red_c;
    logic                     q_valid;
    logic [NODES*WIDTH-1:0]   q_data;
    logic [SEL_W-1:0]         q_sel;

    if (k == 0) begin : g_src_in
      assign src_valid = bus.in_valid;
      assign src_data  = bus.in_data;
      assign src_sel   = bus.in_sel;
    end else begin : g_src_prev
      assign src_valid = g_lvl[k-1].q_valid;
      assign src_data  = g_lvl[k-1].q_data;
      assign src_sel   = g_lvl[k-1].q_sel;
    end

    mux_tree_level #(
      .NODES (NODES),
      .WIDTH (WIDTH)
    ) u_level (
      .pairs     (src_data),
      .sel       (src_sel[k]),
      .reduced_c (red_c)
    );

    if ((PIPE != 0) || (k == LEVELS - 1)) begin : g_reg
      // Stage register: valid always follows on advance, payload only for real beats.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q_valid <= 1'b0;
          q_data  <= '0;
          q_sel   <= '0;
        end else if (adv) begin
          q_valid <= src_valid;
          if (src_valid) begin
            q_data <= red_c;
            q_sel  <= src_sel;
          end
        end
      end
    end else begin : g_comb
      assign q_valid = src_valid;
      assign q_data  = red_c;
      assign q_sel   = src_sel;
    end
  end

  assign bus.out_valid = g_lvl[LEVELS-1].q_valid;
  assign bus.out_data  = g_lvl[LEVELS-1].q_data;
  assign bus.out_sel   = g_lvl[LEVELS-1].q_sel;

endmodule
